// File: rtl/bc_tx_arbiter.sv
// Round-robin arbiter sharing one broadcast transmitter among four requesters.
// Define BC_ARB_TIMEOUT_EN to build the WAIT_DONE watchdog; otherwise err_o is constant 0.
module bc_tx_arbiter #(
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 40_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req_i,
    input  logic [31:0] req_id_i,
    input  logic        BC_done_i,
    output logic        send_o,
    output logic [7:0]  station_ID_o,
    output logic [3:0]  gnt_o,
    output logic [3:0]  ack_o,
    output logic [3:0]  err_o,
    output logic        busy_o
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_e;

    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    if (GAP_CYCLES < 1 || GAP_CYCLES > 65535 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 32'h03FF_FFFF) begin : g_bad_cfg
        $error("bc_tx_arbiter: GAP_CYCLES or TIMEOUT_CYCLES out of range");
    end

    state_e      state_q, state_d;
    logic        send_q, send_d;
    logic [7:0]  station_id_q, station_id_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [3:0]  ack_q, ack_d;
    logic [3:0]  err_q, err_d;
    logic        busy_q, busy_d;
    logic        bc_done_q;
    logic [1:0]  last_ptr_q, last_ptr_d;
    logic [1:0]  win_q, win_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;

    logic       done_rise;
    logic       timeout;
    logic [1:0] pick;

    // A level already high at launch is stale; only a fresh rising edge completes the frame.
    assign done_rise = BC_done_i & ~bc_done_q;

    // Descending scan so the nearest requester above last_ptr_q is the final assignment.
    always_comb begin
        pick = last_ptr_q;
        for (int k = 4; k >= 1; k--) begin
            if (req_i[2'(last_ptr_q + 2'(k))]) pick = 2'(last_ptr_q + 2'(k));
        end
    end

`ifdef BC_ARB_TIMEOUT_EN
    localparam logic [25:0] TO_LAST = 26'(TIMEOUT_CYCLES - 1);

    logic [25:0] to_cnt_q, to_cnt_d;

    assign to_cnt_d = (state_q == WAIT_DONE) ? to_cnt_q + 26'd1 : 26'd0;
    assign timeout  = (state_q == WAIT_DONE) && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) to_cnt_q <= '0;
        else        to_cnt_q <= to_cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // NOTE: reset is synchronous, so rst_n is sampled here and is absent from the event list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            send_q       <= 1'b0;
            station_id_q <= 8'h00;
            gnt_q        <= '0;
            ack_q        <= '0;
            err_q        <= '0;
            busy_q       <= 1'b0;
            bc_done_q    <= 1'b0;
            last_ptr_q   <= 2'd3;
            win_q        <= 2'd0;
            gap_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            send_q       <= send_d;
            station_id_q <= station_id_d;
            gnt_q        <= gnt_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            bc_done_q    <= BC_done_i;
            last_ptr_q   <= last_ptr_d;
            win_q        <= win_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (req_i != 4'b0000) state_d = LAUNCH;
            LAUNCH:    state_d = WAIT_DONE;
            WAIT_DONE: if (done_rise || timeout) state_d = GAP;
            GAP:       if (gap_cnt_q == GAP_LAST) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // NOTE: every signal gets a default before the case, so no path leaves one unassigned.
    always_comb begin
        send_d       = 1'b0;
        ack_d        = '0;
        err_d        = '0;
        gnt_d        = gnt_q;
        station_id_d = station_id_q;
        last_ptr_d   = last_ptr_q;
        win_d        = win_q;
        gap_cnt_d    = '0;
        busy_d       = (state_d != IDLE);
        unique case (state_q)
            IDLE: begin
                if (req_i != 4'b0000) begin
                    send_d       = 1'b1;
                    win_d        = pick;
                    gnt_d        = 4'b0001 << pick;
                    station_id_d = req_id_i[{pick, 3'b000} +: 8];
                end
            end
            WAIT_DONE: begin
                if (done_rise) begin
                    ack_d[win_q] = 1'b1;
                    gnt_d        = '0;
                    last_ptr_d   = win_q;
                end else if (timeout) begin
                    err_d[win_q] = 1'b1;
                    gnt_d        = '0;
                    last_ptr_d   = win_q;
                end
            end
            GAP:     gap_cnt_d = gap_cnt_q + 16'd1;
            default: ;
        endcase
    end

    assign send_o       = send_q;
    assign station_ID_o = station_id_q;
    assign gnt_o        = gnt_q;
    assign ack_o        = ack_q;
    assign err_o        = err_q;
    assign busy_o       = busy_q;
endmodule

// File: tb/tb_bc_tx_arbiter.sv
// Scoreboard bench for bc_tx_arbiter: expected grants/acks/errs are queued at stimulus time
// and matched when the DUT pulses send/ack/err. Define BC_ARB_TIMEOUT_EN to exercise the watchdog.
module tb_bc_tx_arbiter;
    localparam int GAP = 16;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] id;
    } grant_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_id;
    logic        BC_done;
    logic        send;
    logic [7:0]  station_ID;
    logic [3:0]  gnt, ack, err;
    logic        busy;

    grant_t     gq[$];
    logic [3:0] aq[$];
    logic [3:0] eq[$];

    int n_checks = 0;
    int n_fail   = 0;

    bc_tx_arbiter #(
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .req_id_i    (req_id),
        .BC_done_i   (BC_done),
        .send_o      (send),
        .station_ID_o(station_ID),
        .gnt_o       (gnt),
        .ack_o       (ack),
        .err_o       (err),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: match each pulse against the head of its queue.
    always @(negedge clk) begin : mon
        grant_t     g;
        logic [3:0] e;
        if (rst_n) begin
            if (send) begin
                if (gq.size() == 0) check("send_unexpected", send, 1'b0);
                else begin
                    g = gq.pop_front();
                    check("grant_gnt", gnt, g.gnt);
                    check("grant_id", station_ID, g.id);
                end
            end
            if (ack != 4'b0000) begin
                if (aq.size() == 0) check("ack_unexpected", ack, 4'b0000);
                else begin
                    e = aq.pop_front();
                    check("ack_val", ack, e);
                end
            end
            if (err != 4'b0000) begin
                if (eq.size() == 0) check("err_unexpected", err, 4'b0000);
                else begin
                    e = eq.pop_front();
                    check("err_val", err, e);
                end
                check("ack_err_excl", ack, 4'b0000);
            end
        end
    end

    task automatic wait_send();
        for (int i = 0; i < 60; i++) begin
            tick();
            if (send) break;
        end
        check("send_seen", send, 1'b1);
    endtask

    task automatic wait_ack();
        for (int i = 0; i < 400; i++) begin
            tick();
            if (ack != 4'b0000) break;
        end
        check("ack_seen", (ack != 4'b0000), 1'b1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            tick();
        end
        check("idle_reached", busy, 1'b0);
    endtask

    // One complete frame: grant, completion after done_delay cycles, then gap length check.
    task automatic run_frame(input logic [3:0] exp_gnt, input logic [7:0] exp_id,
                             input int done_delay, input int drop_at, input bit rel);
        int n;
        gq.push_back('{exp_gnt, exp_id});
        aq.push_back(exp_gnt);
        wait_send();
        check("busy_on_grant", busy, 1'b1);
        BC_done = 1'b0;
        for (int i = 1; i <= done_delay; i++) begin
            tick();
            if (i == 1) check("send_width", send, 1'b0);
            if (i == drop_at) req = req & ~exp_gnt;
        end
        BC_done = 1'b1;
        wait_ack();
        check("gnt_clear", gnt, 4'b0000);
        if (rel) req = 4'b0000;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) check("ack_width", ack, 4'b0000);
        end while (busy && n < GAP + 8);
        check("gap_len", n, GAP);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks, ack_cyc, bad;
        rst_n   = 1'b0;
        req     = 4'b0000;
        req_id  = {8'hD3, 8'hA5, 8'hB1, 8'hC0};
        BC_done = 1'b0;
        tick(2);
        check("rst_send", send, 1'b0);
        check("rst_gnt", gnt, 4'b0000);
        check("rst_ack", ack, 4'b0000);
        check("rst_err", err, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_id", station_ID, 8'h00);
        rst_n = 1'b1;
        tick(5);
        check("idle_busy", busy, 1'b0);
        check("idle_gnt", gnt, 4'b0000);

        // Round-robin with all requesters held.
        req = 4'b1111;
        run_frame(4'b0001, 8'hC0, 30, -1, 1'b0);
        run_frame(4'b0010, 8'hB1, 30, -1, 1'b0);
        run_frame(4'b0100, 8'hA5, 30, -1, 1'b0);
        run_frame(4'b1000, 8'hD3, 30, -1, 1'b0);
        run_frame(4'b0001, 8'hC0, 30, -1, 1'b1);

        // Single request, completion 100 cycles after launch.
        req = 4'b0100;
        run_frame(4'b0100, 8'hA5, 100, 1, 1'b1);
        check("station_hold", station_ID, 8'hA5);

        // Stale done level at launch.
        BC_done = 1'b1;
        req     = 4'b0010;
        gq.push_back('{4'b0010, 8'hB1});
        aq.push_back(4'b0010);
        wait_send();
        req     = 4'b0000;
        acks    = 0;
        ack_cyc = -1;
        for (int c = 1; c <= 205; c++) begin
            tick();
            if (ack != 4'b0000) begin
                acks++;
                ack_cyc = c;
            end
            if (c == 2)   BC_done = 1'b0;
            if (c == 200) BC_done = 1'b1;
        end
        check("stale_ack_cnt", acks, 1);
        check("stale_ack_cyc", ack_cyc, 201);
        wait_idle();

        // Request dropped three cycles after the grant.
        req = 4'b0010;
        run_frame(4'b0010, 8'hB1, 20, 3, 1'b1);

`ifdef BC_ARB_TIMEOUT_EN
        req = 4'b0110;
        gq.push_back('{4'b0100, 8'hA5});
        eq.push_back(4'b0100);
        gq.push_back('{4'b0010, 8'hB1});
        aq.push_back(4'b0010);
        wait_send();
        BC_done = 1'b0;
        bad = -1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (err != 4'b0000) begin
                bad = c;
                break;
            end
        end
        check("err_cycle", bad, 51);
        wait_send();
        check("post_to_gnt", gnt, 4'b0010);
        req = 4'b0000;
        tick(5);
        BC_done = 1'b1;
        wait_ack();
        wait_idle();
`else
        req = 4'b0100;
        gq.push_back('{4'b0100, 8'hA5});
        aq.push_back(4'b0100);
        wait_send();
        req     = 4'b0000;
        BC_done = 1'b0;
        bad     = 0;
        for (int c = 0; c < 10000; c++) begin
            tick();
            if (!busy || err != 4'b0000) bad++;
        end
        check("no_timeout", bad, 0);
        BC_done = 1'b1;
        wait_ack();
        wait_idle();
`endif

        // Reset in the middle of WAIT_DONE.
        req = 4'b0010;
        gq.push_back('{4'b0010, 8'hB1});
        wait_send();
        req     = 4'b0000;
        BC_done = 1'b0;
        tick(5);
        rst_n = 1'b0;
        tick();
        check("mid_rst_send", send, 1'b0);
        check("mid_rst_gnt", gnt, 4'b0000);
        check("mid_rst_ack", ack, 4'b0000);
        check("mid_rst_err", err, 4'b0000);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_id", station_ID, 8'h00);
        rst_n = 1'b1;
        tick(3);
        req = 4'b1001;
        run_frame(4'b0001, 8'hC0, 10, 1, 1'b1);

        tick(5);
        check("sb_empty", gq.size() + aq.size() + eq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bc_tx_arbiter.md
BC_TX_ARBITER -- requirements
Module: bc_tx_arbiter

Interface
REQ-001 Parameters SHALL be:
  GAP_CYCLES      16          idle cycles after each transmission before next grant; legal range 1..65535
  TIMEOUT_CYCLES  40_000_000  WAIT_DONE watchdog limit, 26-bit
REQ-002 Ports SHALL be:
  clk         in   1   system clock
  rst_n       in   1   synchronous active-low reset
  req         in   4   per-requester transmit request, level
  req_id      in   32  packed station IDs {id3,id2,id1,id0}
  BC_done     in   1   transmitter completion level: cleared by send, set at end of frame
  send        out  1   one-cycle launch pulse to transmitter
  station_ID  out  8   ID presented to transmitter, stable while busy
  gnt         out  4   one-hot grant, high from launch until completion or timeout
  ack         out  4   one-cycle completion pulse to the granted requester
  err         out  4   one-cycle timeout pulse to the granted requester
  busy        out  1   high in every state except IDLE
REQ-003 The design SHALL use one clock, clk; reset SHALL be synchronous and active-low on rst_n.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, LAUNCH, WAIT_DONE, GAP.
REQ-005 All outputs SHALL be registered; there SHALL be no combinational path from input to output.
REQ-006 In IDLE with req != 0 at edge E0, the block SHALL select the winner by round-robin, searching upward from last_ptr+1 mod 4.
REQ-007 At E0 the block SHALL load gnt[winner]=1 and station_ID=req_id[8*winner+:8], and set send=1 and state=LAUNCH.
REQ-008 send SHALL be high for exactly one cycle (E0 to E1); at E1 the state SHALL become WAIT_DONE.
REQ-009 The block SHALL register BC_done into bc_done_q every cycle; completion SHALL be detected only as BC_done & ~bc_done_q, never on level.
REQ-010 A BC_done level already high at launch SHALL NOT produce ack.
REQ-011 On completion in WAIT_DONE, at the next edge the block SHALL pulse ack[winner] for one cycle, clear gnt, set last_ptr=winner, and enter GAP.
REQ-012 GAP SHALL last exactly GAP_CYCLES cycles, with busy=1 and send=0, then return to IDLE.
REQ-013 req SHALL be sampled only in IDLE; deasserting req after a grant SHALL NOT abort the transmission, and ack SHALL still be issued.
REQ-014 A requester holding req after its ack SHALL be re-eligible; other pending requesters SHALL be granted first.
REQ-015 station_ID SHALL hold its value from E0 until the next grant.
REQ-016 With req=0 in IDLE the block SHALL stay in IDLE with all outputs unchanged and pulses low.
REQ-017 ack and err SHALL never be asserted in the same cycle, and at most one bit of each SHALL be set.

Reset
REQ-018 When rst_n=0 at a clk edge, the block SHALL set: state=IDLE, send=0, gnt=0, ack=0, err=0, busy=0, station_ID=8'h00, bc_done_q=0, last_ptr=3 (requester 0 first), and all counters to 0.
REQ-019 Reset in any state, including mid-transmission, SHALL take effect at that edge; the aborted requester SHALL receive no ack or err.

Configuration
REQ-020 With macro BC_ARB_TIMEOUT_EN defined, a 26-bit counter SHALL run in WAIT_DONE. If it reaches TIMEOUT_CYCLES without completion, the block SHALL pulse err[winner] for one cycle, clear gnt, update last_ptr, and enter GAP.
REQ-021 Without BC_ARB_TIMEOUT_EN, no timeout counter SHALL be built, WAIT_DONE SHALL wait indefinitely, and err SHALL be constant 0.
REQ-022 If completion and timeout occur in the same cycle, completion (ack) SHALL take priority.

Verification
REQ-023 Single request: req=4'b0100, id2=8'hA5 -> send high one cycle after sampling, station_ID=8'hA5, gnt=4'b0100; BC_done rise 100 cycles later -> ack=4'b0100 for one cycle, gnt=0; busy falls 16 cycles later.
REQ-024 Round-robin: req=4'b1111 held, each frame completed -> grant order 0,1,2,3,0, with one ack per frame and a 16-cycle gap between frames.
REQ-025 Stale done: BC_done=1 at launch, falls 2 cycles later, rises at cycle 200 -> exactly one ack, at cycle 201.
REQ-026 Timeout (BC_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=50): no BC_done rise -> err[winner] pulses after 50 WAIT_DONE cycles, no ack, next requester granted after the gap. Without the macro -> busy stays high and err=0 for 10000 cycles.
REQ-027 Reset mid-frame: rst_n=0 for one cycle in WAIT_DONE -> all outputs reach their reset values at that edge; then with req=4'b1001, requester 0 is granted first.
REQ-028 Dropped request: req[1] deasserted 3 cycles after grant -> frame completes and ack=4'b0010 is issued.
